// File: rtl/nexys_starship_repair_arbiter.sv
// Round-robin repair arbiter: shares the switch combo and submit pulse among the
// four room repair requesters, checks submissions and enforces a tick timeout.
`timescale 1ns/1ps

module nexys_starship_repair_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200,
    parameter int         WRONG_W = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               play_flag,
    input  logic               tick,
    input  logic [3:0]         broken_req,
    input  logic [15:0]        target_combo,
    input  logic [3:0]         hex_combo,
    input  logic               submit,
    input  logic               skip,
    output logic [3:0]         grant,
    output logic [1:0]         active_id,
    output logic [3:0]         disp_combo,
    output logic [3:0]         repaired,
    output logic               timeout_evt,
    output logic [WRONG_W-1:0] wrong_cnt,
    output logic               busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARB     = 2'd1;
    localparam logic [1:0] SERVE   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [WRONG_W-1:0] WRONG_SAT = {WRONG_W{1'b1}};
    localparam logic [WRONG_W-1:0] WRONG_ONE = {{(WRONG_W-1){1'b0}}, 1'b1};

    // Returns {found, index} of the first set request at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + i[1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    logic [1:0]         state_r, state_s;
    logic [1:0]         rr_ptr_r, rr_ptr_s;
    logic [7:0]         timer_r, timer_s;
    logic [3:0]         grant_r, grant_s;
    logic [1:0]         active_id_r, active_id_s;
    logic [3:0]         disp_combo_r, disp_combo_s;
    logic [3:0]         repaired_r, repaired_s;
    logic               timeout_evt_r, timeout_evt_s;
    logic [WRONG_W-1:0] wrong_cnt_r, wrong_cnt_s;
    logic               busy_r, busy_s;

    logic [2:0]         pick_s;
    logic               correct_s;
    logic               wrong_s;
    logic               final_tick_s;

    // Submission classification against the combo latched at arbitration.
    always_comb begin
        pick_s       = rr_pick(broken_req, rr_ptr_r);
        correct_s    = submit && (hex_combo == disp_combo_r);
        wrong_s      = submit && (hex_combo != disp_combo_r);
        final_tick_s = tick && (timer_r == 8'd1);
    end

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        timer_s       = timer_r;
        grant_s       = grant_r;
        active_id_s   = active_id_r;
        disp_combo_s  = disp_combo_r;
        repaired_s    = 4'b0000;
        timeout_evt_s = 1'b0;
        wrong_cnt_s   = wrong_cnt_r;

        case (state_r)
            IDLE: begin
                grant_s = 4'b0000;
                if (play_flag && (broken_req != 4'b0000)) begin
                    state_s = ARB;
                end else begin
                    state_s = IDLE;
                end
            end
            ARB: begin
                if (!play_flag) begin
                    state_s = IDLE;
                    grant_s = 4'b0000;
                end else if (pick_s[2]) begin
                    active_id_s  = pick_s[1:0];
                    disp_combo_s = target_combo[{pick_s[1:0], 2'b00} +: 4];
                    timer_s      = TIMEOUT;
                    grant_s      = id_to_onehot(pick_s[1:0]);
                    state_s      = SERVE;
                end else begin
                    state_s = IDLE;
                    grant_s = 4'b0000;
                end
            end
            SERVE: begin
                if (tick && (timer_r > 8'd1)) begin
                    timer_s = timer_r - 8'd1;
                end else begin
                    timer_s = timer_r;
                end
                if (!play_flag) begin
                    state_s = IDLE;
                    grant_s = 4'b0000;
                end else if (correct_s) begin
                    repaired_s = grant_r;
                    grant_s    = 4'b0000;
                    state_s    = RELEASE;
                end else begin
                    if (wrong_s && (wrong_cnt_r != WRONG_SAT)) begin
                        wrong_cnt_s = wrong_cnt_r + WRONG_ONE;
                    end else begin
                        wrong_cnt_s = wrong_cnt_r;
                    end
                    // A wrong submit still counts when it lands on the final tick.
                    if (final_tick_s) begin
                        timeout_evt_s = 1'b1;
                        grant_s       = 4'b0000;
                        state_s       = RELEASE;
                    end else if (skip) begin
                        grant_s = 4'b0000;
                        state_s = RELEASE;
                    end else if (wrong_s) begin
                        state_s = SERVE;
                    end else if (!broken_req[active_id_r]) begin
                        grant_s = 4'b0000;
                        state_s = RELEASE;
                    end else begin
                        state_s = SERVE;
                    end
                end
            end
            RELEASE: begin
                grant_s = 4'b0000;
                state_s = IDLE;
                if (play_flag) begin
                    rr_ptr_s = active_id_r + 2'd1;
                end else begin
                    rr_ptr_s = rr_ptr_r;
                end
            end
            default: begin
                grant_s = 4'b0000;
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= 2'd0;
            timer_r       <= 8'd0;
            grant_r       <= 4'b0000;
            active_id_r   <= 2'd0;
            disp_combo_r  <= 4'h0;
            repaired_r    <= 4'b0000;
            timeout_evt_r <= 1'b0;
            wrong_cnt_r   <= {WRONG_W{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            timer_r       <= timer_s;
            grant_r       <= grant_s;
            active_id_r   <= active_id_s;
            disp_combo_r  <= disp_combo_s;
            repaired_r    <= repaired_s;
            timeout_evt_r <= timeout_evt_s;
            wrong_cnt_r   <= wrong_cnt_s;
            busy_r        <= busy_s;
        end
    end

    assign grant       = grant_r;
    assign active_id   = active_id_r;
    assign disp_combo  = disp_combo_r;
    assign repaired    = repaired_r;
    assign timeout_evt = timeout_evt_r;
    assign wrong_cnt   = wrong_cnt_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_nexys_starship_repair_arbiter.sv
// Scoreboard bench for the repair arbiter: grant/repaired/timeout events are queued
// as stimulus is driven and matched as the DUT produces them.
`timescale 1ns/1ps

module tb_nexys_starship_repair_arbiter;

    localparam logic [1:0] EV_GRANT = 2'd0;
    localparam logic [1:0] EV_REP   = 2'd1;
    localparam logic [1:0] EV_TO    = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        play_flag;
    logic        tick;
    logic [3:0]  broken_req;
    logic [15:0] target_combo;
    logic [3:0]  hex_combo;
    logic        submit;
    logic        skip;
    logic [3:0]  grant;
    logic [1:0]  active_id;
    logic [3:0]  disp_combo;
    logic [3:0]  repaired;
    logic        timeout_evt;
    logic [3:0]  wrong_cnt;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    ev_t  sb_q[$];
    logic [3:0] prev_grant = 4'b0000;

    nexys_starship_repair_arbiter #(.TIMEOUT(8'd3), .WRONG_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .tick(tick),
        .broken_req(broken_req), .target_combo(target_combo), .hex_combo(hex_combo),
        .submit(submit), .skip(skip), .grant(grant), .active_id(active_id),
        .disp_combo(disp_combo), .repaired(repaired), .timeout_evt(timeout_evt),
        .wrong_cnt(wrong_cnt), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [1:0] kind, input logic [3:0] val);
        sb_q.push_back('{kind: kind, val: val});
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [3:0] val);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected", 16'({kind, val}), 16'hFFFF);
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_event", 16'({kind, val}), 16'({e.kind, e.val}));
        end
    endtask

    // Event monitor, sampling 2 ns after each rising edge.
    always @(posedge Clk) begin
        #2;
        if (Reset && (prev_grant == 4'b0000) && (grant != 4'b0000)) sb_pop(EV_GRANT, grant);
        if (repaired != 4'b0000) sb_pop(EV_REP, repaired);
        if (timeout_evt) sb_pop(EV_TO, 4'b0000);
        prev_grant = grant;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string tag, output int n);
        n = 0;
        while ((grant == 4'b0000) && (n < 20)) begin
            step();
            n++;
        end
        check_eq(tag, 16'(grant), 16'(exp));
    endtask

    task automatic pulse_submit(input logic [3:0] combo);
        hex_combo = combo;
        submit    = 1'b1;
        step();
        submit    = 1'b0;
    endtask

    initial begin
        int         n;
        logic [3:0] exp_g;
        logic [15:0] tgt;

        Reset = 1'b0; play_flag = 1'b1; tick = 1'b0; broken_req = 4'hF;
        target_combo = 16'h4321; hex_combo = 4'h0; submit = 1'b0; skip = 1'b0;
        tgt = 16'h4321;

        // Reset held with requests pending
        step(); step();
        check_eq("rst_grant", 16'(grant), 16'h0);
        check_eq("rst_busy", 16'(busy), 16'h0);
        check_eq("rst_wrong", 16'(wrong_cnt), 16'h0);
        check_eq("rst_disp", 16'(disp_combo), 16'h0);
        check_eq("rst_id", 16'(active_id), 16'h0);
        sb_push(EV_GRANT, 4'b0001);
        Reset = 1'b1;
        step();
        check_eq("arb_busy", 16'(busy), 16'h1);
        check_eq("arb_grant", 16'(grant), 16'h0);
        step();
        check_eq("rst_first_grant", 16'(grant), 16'h1);

        // Round-robin with all rooms requesting
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            if (i > 0) sb_push(EV_GRANT, exp_g);
            wait_grant(exp_g, "rr_grant", n);
            if (i > 0) check_eq("rr_latency", 16'(n), 16'd3);
            check_eq("rr_disp", 16'(disp_combo), 16'((tgt >> (4 * (i % 4))) & 16'hF));
            sb_push(EV_REP, exp_g);
            pulse_submit(4'((tgt >> (4 * (i % 4))) & 16'hF));
            if (i == 4) broken_req = 4'b0000;
            check_eq("rr_repaired", 16'(repaired), 16'(exp_g));
            check_eq("rr_release", 16'(grant), 16'h0);
        end

        // Single repair of room 2
        step(); step();
        target_combo = 16'h4A21;
        broken_req   = 4'b0100;
        sb_push(EV_GRANT, 4'b0100);
        wait_grant(4'b0100, "single_grant", n);
        check_eq("single_disp", 16'(disp_combo), 16'hA);
        check_eq("single_id", 16'(active_id), 16'd2);
        sb_push(EV_REP, 4'b0100);
        pulse_submit(4'hA);
        broken_req = 4'b1001;
        target_combo = 16'h5A21;
        check_eq("single_rep", 16'(repaired), 16'h4);
        check_eq("single_rel", 16'(grant), 16'h0);
        step();
        check_eq("single_pulse1", 16'(repaired), 16'h0);

        // Pointer now at room 3; wrong combos there
        sb_push(EV_GRANT, 4'b1000);
        wait_grant(4'b1000, "ptr_grant3", n);
        check_eq("wrong_disp", 16'(disp_combo), 16'h5);
        target_combo = 16'h0000;
        for (int i = 0; i < 3; i++) pulse_submit(4'h3);
        check_eq("wrong_cnt3", 16'(wrong_cnt), 16'd3);
        check_eq("wrong_hold", 16'(grant), 16'h8);
        for (int i = 0; i < 14; i++) pulse_submit(4'h3);
        check_eq("wrong_sat", 16'(wrong_cnt), 16'd15);
        check_eq("disp_latched", 16'(disp_combo), 16'h5);
        sb_push(EV_REP, 4'b1000);
        pulse_submit(4'h5);
        check_eq("wrong_then_ok", 16'(repaired), 16'h8);

        // Timeout on room 0 after three ticks
        sb_push(EV_GRANT, 4'b0001);
        wait_grant(4'b0001, "to_grant", n);
        sb_push(EV_TO, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (i < 2) begin
                check_eq("to_early", 16'(timeout_evt), 16'h0);
                step();
            end
        end
        check_eq("to_evt", 16'(timeout_evt), 16'h1);
        check_eq("to_norep", 16'(repaired), 16'h0);
        check_eq("to_rel", 16'(grant), 16'h0);
        step();
        check_eq("to_pulse1", 16'(timeout_evt), 16'h0);

        // Correct submit on the final tick beats the timeout
        sb_push(EV_GRANT, 4'b1000);
        wait_grant(4'b1000, "to2_grant", n);
        tick = 1'b1; step(); step(); tick = 1'b0;
        sb_push(EV_REP, 4'b1000);
        tick = 1'b1; hex_combo = 4'h0; submit = 1'b1;
        step();
        tick = 1'b0; submit = 1'b0;
        check_eq("tie_rep", 16'(repaired), 16'h8);
        check_eq("tie_noto", 16'(timeout_evt), 16'h0);

        // play_flag drop in SERVE
        sb_push(EV_GRANT, 4'b0001);
        wait_grant(4'b0001, "abort_grant", n);
        play_flag = 1'b0;
        step();
        check_eq("play_grant", 16'(grant), 16'h0);
        check_eq("play_busy", 16'(busy), 16'h0);
        step();
        sb_push(EV_GRANT, 4'b0001);
        play_flag = 1'b1;
        wait_grant(4'b0001, "play_regrant", n);

        // Request withdrawn in SERVE
        broken_req = 4'b1000;
        sb_push(EV_GRANT, 4'b1000);
        step();
        check_eq("wd_grant", 16'(grant), 16'h0);
        check_eq("wd_busy", 16'(busy), 16'h1);
        wait_grant(4'b1000, "wd_next", n);

        // Skip abandons and advances the pointer
        broken_req = 4'b1001;
        skip = 1'b1; step(); skip = 1'b0;
        check_eq("skip_grant", 16'(grant), 16'h0);
        sb_push(EV_GRANT, 4'b0001);
        wait_grant(4'b0001, "skip_next", n);

        broken_req = 4'b0000;
        play_flag  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
